// File: rtl/sdram_ctrl_pkg.sv
// Shared types and constants for the controller-side buffer RAM port.
package sdram_ctrl_pkg;

    localparam int DPRAM_DW     = 32;
    localparam int DPRAM_BEW    = 4;
    localparam int DPRAM_RD_LAT = 2;
    localparam int PORT_IW      = 3;

    // Read-return tag carried alongside the RAM access pipeline.
    typedef struct packed {
        logic               valid;
        logic [PORT_IW-1:0] port;
    } rd_tag_t;

endpackage

// File: rtl/dpram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after start.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);

    int p;

    // Scan from the farthest offset back to start so the nearest request wins last.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        p     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            p = int'(start) + k;
            if (p >= N) begin
                p = p - N;
            end
            if (req[p]) begin
                grant    = '0;
                grant[p] = 1'b1;
                idx      = IW'(p);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter with bounded locked bursts sharing one byte-enabled RAM port.
module dpram_port_arbiter
    import sdram_ctrl_pkg::*;
#(
    parameter int NUM_PORTS  = 3,
    parameter int ADDR_WIDTH = 9,
    parameter int MAX_BURST  = 8
) (
    input  logic                            wb_clk,
    input  logic                            wb_rst_n,
    input  logic [NUM_PORTS-1:0]            req_i,
    input  logic [NUM_PORTS-1:0]            lock_i,
    input  logic [NUM_PORTS*DPRAM_BEW-1:0]  we_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_PORTS*DPRAM_DW-1:0]   dat_i,
    output logic [NUM_PORTS-1:0]            ack_o,
    output logic [NUM_PORTS-1:0]            rvalid_o,
    output logic [DPRAM_DW-1:0]             dat_o,
    output logic [ADDR_WIDTH-1:0]           ram_addr_o,
    output logic [DPRAM_BEW-1:0]            ram_we_o,
    output logic [DPRAM_DW-1:0]             ram_di_o,
    input  logic [DPRAM_DW-1:0]             ram_do_i
);

    localparam int OW = $clog2(NUM_PORTS);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [OW-1:0] LAST_PORT = OW'(NUM_PORTS - 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    logic [OW-1:0]         owner_reg, owner_next, owner_eff, start_ptr;
    logic [OW-1:0]         rr_idx, win_idx;
    logic [BW-1:0]         burst_cnt_reg, burst_cnt_next;
    logic [NUM_PORTS-1:0]  rr_grant, win_grant, rvalid_next;
    logic                  rr_found, hold_owner, win_any, win_rd;
    logic [DPRAM_BEW-1:0]  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DPRAM_DW-1:0]   sel_dat;
    rd_tag_t               tag_in;
    rd_tag_t               tag_reg [DPRAM_RD_LAT-1];

    assign owner_eff  = (owner_reg > LAST_PORT) ? LAST_PORT : owner_reg;
    assign start_ptr  = (owner_eff == LAST_PORT) ? '0 : owner_eff + 1'b1;
    assign hold_owner = req_i[owner_eff] & lock_i[owner_eff] & (burst_cnt_reg < BURST_MAX);

    rr_pick #(
        .N  (NUM_PORTS),
        .IW (OW)
    ) u_rr_pick (
        .req   (req_i),
        .start (start_ptr),
        .grant (rr_grant),
        .idx   (rr_idx),
        .found (rr_found)
    );

    always_comb begin
        win_grant = rr_grant;
        win_idx   = rr_idx;
        win_any   = rr_found;
        if (hold_owner) begin
            win_grant            = '0;
            win_grant[owner_eff] = 1'b1;
            win_idx              = owner_eff;
            win_any              = 1'b1;
        end
        sel_we   = we_i[int'(win_idx)*DPRAM_BEW +: DPRAM_BEW];
        sel_addr = addr_i[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        sel_dat  = dat_i[int'(win_idx)*DPRAM_DW +: DPRAM_DW];
        win_rd   = win_any & (sel_we == '0);
    end

    assign ack_o = wb_rst_n ? win_grant : '0;
    assign dat_o = ram_do_i;

    // The count saturates so an unlocked owner that keeps winning cannot re-arm its lock.
    always_comb begin
        owner_next     = owner_reg;
        burst_cnt_next = burst_cnt_reg;
        if (!win_any) begin
            burst_cnt_next = '0;
        end else if (win_idx == owner_eff) begin
            owner_next = win_idx;
            if (burst_cnt_reg != BURST_MAX) begin
                burst_cnt_next = burst_cnt_reg + 1'b1;
            end
        end else begin
            owner_next     = win_idx;
            burst_cnt_next = BW'(1);
        end
    end

    always_comb begin
        tag_in              = '0;
        tag_in.valid        = win_rd;
        tag_in.port[OW-1:0] = win_idx;
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            owner_reg     <= LAST_PORT;
            burst_cnt_reg <= '0;
            ram_addr_o    <= '0;
            ram_we_o      <= '0;
            ram_di_o      <= '0;
        end else begin
            owner_reg     <= owner_next;
            burst_cnt_reg <= burst_cnt_next;
            if (win_any) begin
                ram_addr_o <= sel_addr;
                ram_we_o   <= sel_we;
                ram_di_o   <= sel_dat;
            end else begin
                ram_we_o   <= '0;
            end
        end
    end

    // Tag stages track the command through the RAM; the final stage is the rvalid register.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            for (int k = 0; k < DPRAM_RD_LAT - 1; k++) begin
                tag_reg[k] <= '0;
            end
            rvalid_o <= '0;
        end else begin
            tag_reg[0] <= tag_in;
            for (int k = 1; k < DPRAM_RD_LAT - 1; k++) begin
                tag_reg[k] <= tag_reg[k-1];
            end
            rvalid_o <= rvalid_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_rvalid
            assign rvalid_next[gi] = tag_reg[DPRAM_RD_LAT-2].valid &&
                                     (int'(tag_reg[DPRAM_RD_LAT-2].port) == gi);
        end
    endgenerate

endmodule

// File: doc/dpram_port_arbiter.md
# dpram_port_arbiter

Round-robin arbiter that shares one 32-bit port of the byte-enabled dual-port buffer RAM among `NUM_PORTS` requesters in the controller clock domain. It registers the winning command onto the RAM port and acknowledges the winner in the same cycle. It returns read data to the correct requester with fixed latency. It also supports locked bursts, bounded by `MAX_BURST` for fairness. The other RAM port is outside this block and is not arbitrated here.

## Interface
Parameters:
- `NUM_PORTS`, 3: number of requesters, 2..8.
- `ADDR_WIDTH`, 9: RAM word address width.
- `MAX_BURST`, 8: maximum consecutive grants to one locked requester, ≥1.

Ports:
- `wb_clk` in 1: single clock. Everything is rising-edge.
- `wb_rst_n` in 1: asynchronous, active-low reset.
- `req_i` in NUM_PORTS: access request per port, held until acked.
- `lock_i` in NUM_PORTS: requester wants to keep the grant for its next access.
- `we_i` in NUM_PORTS*4: byte write enables. All zero means a read. Port i uses `[4i+3:4i]`.
- `addr_i` in NUM_PORTS*ADDR_WIDTH: word address per port.
- `dat_i` in NUM_PORTS*32: write data per port.
- `ack_o` out NUM_PORTS: combinational, one-hot; command accepted this cycle.
- `rvalid_o` out NUM_PORTS: registered; read data valid on `dat_o` for that port.
- `dat_o` out 32: read data, equal to `ram_do_i`.
- `ram_addr_o` out ADDR_WIDTH: registered RAM address.
- `ram_we_o` out 4: registered RAM byte write enables.
- `ram_di_o` out 32: registered RAM write data.
- `ram_do_i` in 32: RAM read data, one cycle after the command is presented.

## Operation
- **Arbitration.** Each cycle, select a winner w among the asserted `req_i`. The search starts at `owner+1` modulo NUM_PORTS, so the port after the last winner has top priority. Drive `ack_o[w]`=1 and no other ack; with no requests, all acks are 0.
- **Locked burst.** If the owner has `req_i` and `lock_i` high and `burst_cnt < MAX_BURST`, the owner wins regardless of the others.
  - `burst_cnt` increments on each owner grant.
  - It resets to 1 when a different port wins.
  - It resets to 0 on an idle cycle.
- **Burst release.** The reservation ends when the owner's `req_i` drops; a gap cycle goes to the others or idles. When `burst_cnt` reaches MAX_BURST, the next arbitration ignores the owner's lock and rotates normally.
- **Command stage.** At the edge ending a grant cycle, latch the winner's `addr_i`, `we_i` and `dat_i` into `ram_addr_o`, `ram_we_o` and `ram_di_o`. On an idle cycle, `ram_we_o`←0 and address/data are held.
- **Read return.** A read grant (we=0) pushes `{valid, w}` into a 2-stage shift register. Stage 2 drives `rvalid_o[w]` one-hot. Write grants push valid=0.
- **Widths.** `burst_cnt` is $clog2(MAX_BURST+1) bits and `owner` is $clog2(NUM_PORTS) bits. Any illegal owner value is treated as NUM_PORTS-1.
- **Other RAM port.** Same-address collisions with the other RAM port resolve in the RAM (read-before-write). This block does not detect them.

## Timing
- **Reset values.** `ram_addr_o`=0, `ram_we_o`=0, `ram_di_o`=0, `rvalid_o`=0, `owner`=NUM_PORTS-1 (port 0 first), `burst_cnt`=0. `ack_o` is combinational, so it is 0 whenever `wb_rst_n`=0.
- **Grant cycle t.** `ack_o[w]`=1 in cycle t. The requester advances on the edge ending t, so one port can issue back-to-back, one access per cycle.
- **Command presentation.** The command is on the RAM pins during t+1, and the RAM samples it at the edge ending t+1.
- **Read latency.** `rvalid_o[w]` and `dat_o` are valid during t+2; fixed latency is 2 cycles from ack.
- **Write then read.** A write granted at t followed by a read of the same address granted at t+1 returns the new data.
- **Reset mid-operation.** Asynchronously clears the pipeline. In-flight reads produce no `rvalid_o`, and no stale `ram_we_o` write occurs after reset assertion.

## Structure
- The shared package `sdram_ctrl_pkg` holds:
  - `DPRAM_DW`=32 and `DPRAM_BEW`=4;
  - `DPRAM_RD_LAT`=2 (ack to rvalid);
  - a typedef for the `{valid, port}` read-tag pipeline entry.
- Sub-module `rr_pick`: a combinational round-robin priority picker with a request vector and start pointer as inputs, and one-hot grant plus index as outputs. The top level holds the owner/burst state and the pipelines.

## Test plan
- **Reset.** Hold `wb_rst_n`=0 with all `req_i` high → all acks, `rvalid_o` and `ram_we_o` are 0. After release, the first grant goes to port 0.
- **Single-port reads.** Port 0 reads addr 5, 6, 7 back to back (RAM preloaded with 0x500, 0x600, 0x700) → acks in t, t+1, t+2; `rvalid_o[0]` in t+2..t+4 with those values in order.
- **Round robin.** Ports 0, 1, 2 request continuously, unlocked → grant order 0, 1, 2, 0, 1, 2; each port's `rvalid` lands exactly 2 cycles after its ack.
- **Burst limit.** With MAX_BURST=8, port 1 requests locked while port 0 requests → port 1 gets 8 consecutive acks, then port 0 gets 1, then port 1 resumes.
- **Byte-enable write then read.** Addr 3 holds 0x11223344. Port 0 writes we=0011 with 0xAABBCCDD at t, and port 1 reads addr 3 at t+1 → `rvalid_o[1]` at t+3 with 0x1122CCDD.
- **Reset mid-read.** Assert reset one cycle after a read ack → no `rvalid_o` pulse ever appears for that read, and all outputs are at reset values.
